// File: rtl/stack_arbiter.sv
// Shared LIFO stack with a two-requester round-robin arbiter.
// Each push/pop transaction runs IDLE -> EXEC -> RESP and reports overflow/underflow.
module stack_arbiter #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [1:0]    req,
  input  logic [1:0]    op,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic [1:0]    gnt,
  output logic [1:0]    done,
  output logic          err,
  output logic [DW-1:0] rdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam int unsigned CW = AW + 1;
  localparam logic [AW:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state, state_d;
  logic          op_q, op_d;
  logic [DW-1:0] data_q, data_d;
  logic          last, last_d;
  logic [1:0]    gnt_d, done_d;
  logic          err_d;
  logic [DW-1:0] rdata_d;
  logic [AW:0]   count_d;
  logic [AW:0]   count_m1;
  logic          mem_we;
  logic          win;
  logic [DW-1:0] mem [DEPTH];

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign count_m1 = count - CW'(1);

  // Under contention the requester not granted last wins
  assign win = (req == 2'b11) ? ~last : req[1];

  always_comb begin
    state_d = state;
    op_d    = op_q;
    data_d  = data_q;
    last_d  = last;
    gnt_d   = gnt;
    done_d  = '0;
    err_d   = 1'b0;
    rdata_d = rdata;
    count_d = count;
    mem_we  = 1'b0;
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          op_d    = op[win];
          data_d  = win ? wdata1 : wdata0;
          last_d  = win;
          gnt_d   = win ? 2'b10 : 2'b01;
          state_d = EXEC;
        end
      end
      EXEC: begin
        done_d  = gnt;
        state_d = RESP;
        if (!op_q) begin
          if (full) begin
            err_d = 1'b1;
          end else begin
            mem_we  = 1'b1;
            count_d = count + CW'(1);
          end
        end else begin
          if (empty) begin
            err_d = 1'b1;
          end else begin
            rdata_d = mem[count_m1[AW-1:0]];
            count_d = count_m1;
          end
        end
      end
      RESP: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      op_q   <= 1'b0;
      data_q <= '0;
      last   <= 1'b1;
      gnt    <= '0;
      done   <= '0;
      err    <= 1'b0;
      rdata  <= '0;
      count  <= '0;
    end else begin
      state  <= state_d;
      op_q   <= op_d;
      data_q <= data_d;
      last   <= last_d;
      gnt    <= gnt_d;
      done   <= done_d;
      err    <= err_d;
      rdata  <= rdata_d;
      count  <= count_d;
    end
  end

  // Storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[count[AW-1:0]] <= data_q;
  end

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter: transaction-level stack/arbiter model fills a
// scoreboard, which is checked against each done pulse from the DUT.
module tb_stack_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] req, op;
  logic [7:0] wdata0, wdata1;
  logic [1:0] gnt, done;
  logic       err;
  logic [7:0] rdata;
  logic [3:0] count;
  logic       full, empty;

  int checks = 0;
  int errors = 0;

  typedef struct {logic op; logic [7:0] data;} rq_t;
  typedef struct {logic [1:0] done; logic err; logic [7:0] rdata; logic [3:0] count;} exp_t;

  rq_t  q0[$], q1[$];
  exp_t sb[$];

  int         mcount;
  logic [7:0] mstk [8];
  logic [7:0] mrdata;
  logic       mlast;

  stack_arbiter #(.DW(8), .DEPTH(8), .AW(3)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .op(op),
    .wdata0(wdata0), .wdata1(wdata1), .gnt(gnt), .done(done),
    .err(err), .rdata(rdata), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mcount = 0;
    mrdata = 8'h00;
    mlast  = 1'b1;
  endtask

  // Transaction-level prediction of service order and stack results
  task automatic model_plan();
    rq_t a[$];
    rq_t b[$];
    a = q0;
    b = q1;
    while (a.size() > 0 || b.size() > 0) begin
      logic id;
      rq_t  t;
      exp_t e;
      if (a.size() > 0 && b.size() > 0) id = ~mlast;
      else id = (b.size() > 0);
      mlast = id;
      if (id) t = b.pop_front();
      else t = a.pop_front();
      e.err = 1'b0;
      if (t.op == 1'b0) begin
        if (mcount == 8) e.err = 1'b1;
        else begin
          mstk[mcount] = t.data;
          mcount++;
        end
      end else begin
        if (mcount == 0) e.err = 1'b1;
        else begin
          mcount--;
          mrdata = mstk[mcount];
        end
      end
      e.done  = id ? 2'b10 : 2'b01;
      e.rdata = mrdata;
      e.count = 4'(mcount);
      sb.push_back(e);
    end
  endtask

  task automatic push_rq(input int who, input logic o, input logic [7:0] d);
    rq_t t;
    t.op   = o;
    t.data = d;
    if (who == 0) q0.push_back(t);
    else q1.push_back(t);
  endtask

  task automatic run_ops(input string tag);
    int         cyc;
    int         last_done;
    logic [1:0] prev_gnt;
    exp_t       e;
    model_plan();
    req = 2'b00;
    @(negedge clk);
    cyc       = 0;
    last_done = -1;
    prev_gnt  = 2'b00;
    while ((q0.size() > 0 || q1.size() > 0) && cyc < 400) begin
      req = {q1.size() > 0, q0.size() > 0};
      if (q0.size() > 0) begin op[0] = q0[0].op; wdata0 = q0[0].data; end
      if (q1.size() > 0) begin op[1] = q1[0].op; wdata1 = q1[0].data; end
      @(negedge clk);
      cyc++;
      if (done != 2'b00) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL %s_extra_done: got %0h expected none", tag, done);
        end else begin
          e = sb.pop_front();
          check({tag, "_done"}, done, e.done);
          check({tag, "_gnt_resp"}, gnt, e.done);
          check({tag, "_gnt_exec"}, prev_gnt, e.done);
          check({tag, "_err"}, err, e.err);
          check({tag, "_rdata"}, rdata, e.rdata);
          check({tag, "_count"}, count, e.count);
          check({tag, "_full"}, full, e.count == 4'd8);
          check({tag, "_empty"}, empty, e.count == 4'd0);
          check({tag, "_latency"}, cyc - last_done, 3);
        end
        if (done[1]) begin if (q1.size() > 0) q1.delete(0); end
        else begin if (q0.size() > 0) q0.delete(0); end
        last_done = cyc;
      end
      prev_gnt = gnt;
    end
    req = 2'b00;
    if (cyc >= 400) begin
      checks++;
      errors++;
      $error("FAIL %s_timeout: got %0d cycles expected under 400", tag, cyc);
      q0.delete();
      q1.delete();
    end
    check({tag, "_sb_left"}, sb.size(), 0);
    sb.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = 2'b00;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  initial begin
    req    = 2'b00;
    op     = 2'b00;
    wdata0 = 8'h00;
    wdata1 = 8'h00;
    do_reset();
    check("rst_gnt", gnt, 2'b00);
    check("rst_done", done, 2'b00);
    check("rst_err", err, 1'b0);
    check("rst_count", count, 4'd0);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_rdata", rdata, 8'h00);

    push_rq(0, 1'b0, 8'hA5);
    run_ops("single_push");
    push_rq(1, 1'b1, 8'h00);
    run_ops("single_pop");

    push_rq(0, 1'b0, 8'h11);
    push_rq(1, 1'b0, 8'h22);
    run_ops("contend_push");
    push_rq(0, 1'b1, 8'h00);
    push_rq(0, 1'b1, 8'h00);
    run_ops("contend_pop");

    for (int i = 0; i < 3; i++) begin
      push_rq(0, 1'b0, 8'(8'h40 + i));
      push_rq(1, 1'b0, 8'(8'h50 + i));
    end
    run_ops("alternate");

    // Abort a push while it sits in EXEC
    @(negedge clk);
    req    = 2'b01;
    op     = 2'b00;
    wdata0 = 8'h55;
    @(negedge clk);
    check("mid_gnt_exec", gnt, 2'b01);
    reset_n = 1'b0;
    #1;
    req = 2'b00;
    check("mid_rst_gnt", gnt, 2'b00);
    check("mid_rst_count", count, 4'd0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    @(negedge clk);
    check("mid_rel_done", done, 2'b00);
    check("mid_rel_count", count, 4'd0);
    check("mid_rel_empty", empty, 1'b1);
    push_rq(0, 1'b0, 8'h77);
    push_rq(1, 1'b0, 8'h88);
    run_ops("mid_contend");

    push_rq(0, 1'b1, 8'h00);
    push_rq(0, 1'b1, 8'h00);
    push_rq(0, 1'b0, 8'h3C);
    push_rq(0, 1'b1, 8'h00);
    push_rq(0, 1'b1, 8'h00);
    run_ops("underflow");
    check("underflow_hold_rdata", rdata, 8'h3C);

    for (int i = 0; i < 9; i++) push_rq(1, 1'b0, 8'(i));
    push_rq(1, 1'b1, 8'h00);
    run_ops("overflow");
    check("overflow_final_count", count, 4'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_arbiter.md
Name: stack_arbiter

Overview:
- Shared LIFO stack plus two-port round-robin arbiter: owns DEPTH x DW storage and the top-of-stack pointer.
- Sequences push/pop transactions from two independent requesters (e.g. two control FSMs sharing one return/operand stack).
- Reports overflow/underflow per transaction and exposes full/empty/count status.

Parameters:
DW, 8, data width of each stack entry
DEPTH, 8, number of stack entries (power of 2, >=2)
AW, 3, log2(DEPTH); count is AW+1 bits

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
req  input  2  per-requester transaction request (level)
op  input  2  per-requester operation: 0 = push, 1 = pop
wdata0  input  DW  push data, requester 0
wdata1  input  DW  push data, requester 1
gnt  output  2  one-hot grant, owner of the transaction in flight
done  output  2  one-hot completion pulse, 1 cycle
err  output  1  transaction error (overflow/underflow), valid with done
rdata  output  DW  pop data, valid with done on a successful pop, held until next successful pop
count  output  AW+1  entries currently stored, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0

Behaviour:
- Reset (async, reset_n=0): state=IDLE, gnt=0, done=0, err=0, rdata=0, count=0, full=0, empty=1, rr pointer = "last granted = 1". Storage array not reset. Any transaction in flight is aborted; no done issued.
- FSM states: IDLE -> EXEC -> RESP -> IDLE. No other transitions; a transaction always takes exactly 3 cycles.
- IDLE:
  - If req != 0, select winner, latch winner id, op[id] and wdata[id], update rr pointer, go to EXEC.
  - Else stay in IDLE.
- Arbitration:
  - Single requester wins immediately.
  - Both requesting: the requester not granted last wins (strict alternation under continuous contention).
- EXEC (gnt[id]=1):
  - Push, count<DEPTH: mem[count]<=data; count<=count+1.
  - Push, count==DEPTH: no write, count unchanged, set err.
  - Pop, count>0: rdata<=mem[count-1]; count<=count-1.
  - Pop, count==0: rdata unchanged, count unchanged, set err.
  - Go to RESP.
- RESP: gnt[id]=1, done[id]=1, err valid (0 on success); go to IDLE. err clears to 0 on leaving RESP.
- Timing: req sampled high in IDLE cycle n -> gnt high cycles n+1, n+2; done high cycle n+2; updated count/full/empty visible from cycle n+2.
- req/op/wdata ignored in EXEC and RESP.
- Requester protocol: hold req/op/wdata stable until done is sampled. At that edge, drop req or present the next operation for back-to-back use. The arbiter re-samples in the following IDLE cycle.
- full/empty are decoded from the count register (no extra latency).
- Arithmetic: count is AW+1 bits and never wraps. Stack address is count[AW-1:0] for push and (count-1)[AW-1:0] for pop.

Test Plan:
- Reset: hold reset_n=0, then release -> gnt=00, done=00, err=0, count=0, empty=1, full=0, rdata=0.
- Single op: req=01 push 0xA5 -> gnt=01 for 2 cycles, done=01 in 3rd cycle, err=0, count=1. Then req=10 pop -> done=10, rdata=0xA5, count=0, empty=1.
- Contention: after reset, req=11 both push (0x11 from 0, 0x22 from 1) -> requester 0 served first, then 1. Two pops return 0x22 then 0x11. With continuous pushes from both, grants alternate 01,10,01,10.
- Overflow: 8 pushes 0x00..0x07 -> count=8, full=1. 9th push -> err=1 with done, count=8. Next pop -> rdata=0x07, err=0, count=7.
- Underflow: pop on empty with rdata=0x3C from a prior pop -> err=1, count=0, rdata stays 0x3C.
- Mid-op reset: assert reset_n=0 during EXEC of a push -> no done, count=0, FSM in IDLE. With req=11 after release, requester 0 granted first.
